vga_timing_gen: RTL and testbench

Generates the raster scan that the sprite renderers and the background drawer consume: DrawX, DrawY, the active-video flag `blank`, and the sync pulses hs and vs. It drives the pixel-coordinate side of the sprite interface; each sprite module samples DrawX/DrawY/blank on vga_clk. It also produces a one-cycle frame_start pulse and an 8-bit frame counter, which game logic uses to step sprite animation frames.

---
 rtl/vga_timing_gen.sv | 82 ++++++++
 tb/tb_vga_timing_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, registered sync/blank, frame pulse and counter.
// Every output is a flop; sync and blank are decoded from next-state counters so they match DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       clk_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Both totals are expected to fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hs_on;
  logic       vs_on;
  logic       vis_nxt;
  logic       at_origin;

  always_comb begin
    x_nxt = DrawX + 10'd1;
    y_nxt = DrawY;
    if (DrawX == H_LAST) begin
      x_nxt = 10'd0;
      y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
    end
    hs_on     = (int'(x_nxt) >= HS_START) && (int'(x_nxt) < HS_END);
    vs_on     = (int'(y_nxt) >= VS_START) && (int'(y_nxt) < VS_END);
    vis_nxt   = (int'(x_nxt) < H_VISIBLE) && (int'(y_nxt) < V_VISIBLE);
    at_origin = (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      frame_start <= 1'b0;
      frame_count <= 8'hFF;
    end else begin
      // frame_start clears on every edge so it stays one vga_clk wide even at half rate
      frame_start <= 1'b0;
      if (clk_en) begin
        DrawX <= x_nxt;
        DrawY <= y_nxt;
        hs    <= hs_on ? SYNC_POL : ~SYNC_POL;
        vs    <= vs_on ? SYNC_POL : ~SYNC_POL;
        blank <= vis_nxt;
        if (at_origin) begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing instance for line/sync checks, plus a tiny-timing instance
// (15x10 frame) so full-frame and 256-frame behaviour fit in a short run.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic clk_en  = 1'b0;

  logic       d_hs, d_vs, d_blank, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       s_hs, s_vs, s_blank, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  int total = 0;
  int bad   = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen u_dut (
    .vga_clk(vga_clk), .reset(reset), .clk_en(clk_en),
    .hs(d_hs), .vs(d_vs), .blank(d_blank), .DrawX(d_x), .DrawY(d_y),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  // small timing: H 8+2+3+2=15 (hs at x 10..12), V 6+1+2+1=10 (vs at y 7..8)
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset), .clk_en(clk_en),
    .hs(s_hs), .vs(s_vs), .blank(s_blank), .DrawX(s_x), .DrawY(s_y),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct {
    logic en;
    int   x;
    int   y;
    logic b;
    logic h;
    logic fs;
    int   fc;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    reset  = 1'b1;
    clk_en = 1'b0;
    @(negedge vga_clk);
    reset  = 1'b0;
  endtask

  initial begin
    int first, second, vs_lo, bl_hi, fs_hi, hold_err;
    int b639, b640, hs_lo, hs_first, hs_last, found, n;
    logic [9:0] px, py;
    logic ph, pv, pb;
    logic [7:0] pfc;

    tbl[0]  = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 0};
    tbl[1]  = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[6]  = '{1'b1, 5, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[7]  = '{1'b1, 6, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[8]  = '{1'b1, 7, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[9]  = '{1'b1, 8, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b1, 9, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b1, 10, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[12] = '{1'b0, 10, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[13] = '{1'b1, 11, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b1, 12, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[15] = '{1'b1, 13, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[16] = '{1'b1, 14, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[17] = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b0, 0};
    tbl[18] = '{1'b0, 0, 1, 1'b1, 1'b1, 1'b0, 0};
    tbl[19] = '{1'b1, 1, 1, 1'b1, 1'b1, 1'b0, 0};

    // reset values on both instances
    @(negedge vga_clk);
    chk("rst_dx", int'(d_x), 799);
    chk("rst_dy", int'(d_y), 524);
    chk("rst_dhs", int'(d_hs), 1);
    chk("rst_dvs", int'(d_vs), 1);
    chk("rst_dblank", int'(d_blank), 0);
    chk("rst_dfs", int'(d_fs), 0);
    chk("rst_dfc", int'(d_fc), 255);
    chk("rst_sx", int'(s_x), 14);
    chk("rst_sy", int'(s_y), 9);
    reset = 1'b0;

    // table: first line of the small instance, with hold cycles
    for (int i = 0; i < 20; i++) begin
      clk_en = tbl[i].en;
      @(negedge vga_clk);
      chk($sformatf("tbl%0d_x", i), int'(s_x), tbl[i].x);
      chk($sformatf("tbl%0d_y", i), int'(s_y), tbl[i].y);
      chk($sformatf("tbl%0d_blank", i), int'(s_blank), int'(tbl[i].b));
      chk($sformatf("tbl%0d_hs", i), int'(s_hs), int'(tbl[i].h));
      chk($sformatf("tbl%0d_vs", i), int'(s_vs), 1);
      chk($sformatf("tbl%0d_fs", i), int'(s_fs), int'(tbl[i].fs));
      chk($sformatf("tbl%0d_fc", i), int'(s_fc), tbl[i].fc);
    end

    // full frame on small instance at full rate
    do_reset();
    clk_en = 1'b1;
    first = -1; second = -1; vs_lo = 0; bl_hi = 0; fs_hi = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge vga_clk);
      if (s_fs) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (first >= 0 && second < 0) begin
        if (!s_vs) vs_lo++;
        if (s_blank) bl_hi++;
        if (s_fs) fs_hi++;
      end
    end
    chk("frame_first_fs", first, 0);
    chk("frame_period", second - first, 150);
    chk("frame_vs_low", vs_lo, 30);
    chk("frame_blank_high", bl_hi, 48);
    chk("frame_fs_width", fs_hi, 1);

    // half-rate enable
    do_reset();
    first = -1; second = -1; vs_lo = 0; fs_hi = 0; hold_err = 0;
    px = s_x; py = s_y; ph = s_hs; pv = s_vs; pb = s_blank; pfc = s_fc;
    for (int c = 0; c < 700; c++) begin
      clk_en = (c % 2 == 0);
      @(negedge vga_clk);
      if (s_fs) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (first >= 0 && second < 0) begin
        if (!s_vs) vs_lo++;
        if (s_fs) fs_hi++;
      end
      if (c % 2 == 1 && (s_x != px || s_y != py || s_hs != ph || s_vs != pv ||
                         s_blank != pb || s_fc != pfc)) hold_err++;
      px = s_x; py = s_y; ph = s_hs; pv = s_vs; pb = s_blank; pfc = s_fc;
    end
    chk("half_period", second - first, 300);
    chk("half_fs_width", fs_hi, 1);
    chk("half_vs_low", vs_lo, 60);
    chk("half_hold_errs", hold_err, 0);

    // default timing: one line
    do_reset();
    clk_en = 1'b1;
    b639 = -1; b640 = -1; hs_lo = 0; hs_first = -1; hs_last = -1;
    for (int c = 0; c < 801; c++) begin
      @(negedge vga_clk);
      if (c == 0) begin
        chk("d_first_x", int'(d_x), 0);
        chk("d_first_y", int'(d_y), 0);
        chk("d_first_blank", int'(d_blank), 1);
        chk("d_first_fs", int'(d_fs), 1);
        chk("d_first_fc", int'(d_fc), 0);
      end
      if (c == 1) begin
        chk("d_second_fs", int'(d_fs), 0);
        chk("d_second_x", int'(d_x), 1);
      end
      if (d_y == 10'd0) begin
        if (d_x == 10'd639) b639 = int'(d_blank);
        if (d_x == 10'd640) b640 = int'(d_blank);
        if (!d_hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(d_x);
          hs_last = int'(d_x);
        end
      end
      if (c == 800) begin
        chk("d_wrap_x", int'(d_x), 0);
        chk("d_wrap_y", int'(d_y), 1);
      end
    end
    chk("d_blank_639", b639, 1);
    chk("d_blank_640", b640, 0);
    chk("d_hs_low_len", hs_lo, 96);
    chk("d_hs_first", hs_first, 656);
    chk("d_hs_last", hs_last, 751);

    // async reset during hsync, default instance (now at y=1)
    found = 0;
    for (int c = 0; c < 900 && !found; c++) begin
      @(negedge vga_clk);
      if (d_x == 10'd700) found = 1;
    end
    chk("d_reach_700", found, 1);
    chk("d_hs_at_700", int'(d_hs), 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_dx", int'(d_x), 799);
    chk("arst_dy", int'(d_y), 524);
    chk("arst_dhs", int'(d_hs), 1);
    chk("arst_dvs", int'(d_vs), 1);
    chk("arst_dblank", int'(d_blank), 0);
    chk("arst_dfc", int'(d_fc), 255);
    @(negedge vga_clk);
    reset = 1'b0;

    // async reset during hsync+vsync, small instance (x=11, y=7)
    do_reset();
    clk_en = 1'b1;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge vga_clk);
      if (s_x == 10'd11 && s_y == 10'd7) found = 1;
    end
    chk("s_reach_sync", found, 1);
    chk("s_hs_in_sync", int'(s_hs), 0);
    chk("s_vs_in_sync", int'(s_vs), 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_sx", int'(s_x), 14);
    chk("arst_sy", int'(s_y), 9);
    chk("arst_shs", int'(s_hs), 1);
    chk("arst_svs", int'(s_vs), 1);
    chk("arst_sfs", int'(s_fs), 0);
    chk("arst_sfc", int'(s_fc), 255);
    @(negedge vga_clk);
    reset = 1'b0;

    // 257 frames: frame_count 0..255 then wraps to 0
    do_reset();
    clk_en = 1'b1;
    n = 0;
    for (int c = 0; c < 257 * 150 + 100 && n < 257; c++) begin
      @(negedge vga_clk);
      if (s_fs) begin
        chk($sformatf("fc_frame%0d", n), int'(s_fc), n % 256);
        n++;
      end
    end
    chk("fc_pulses_seen", n, 257);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
